// File: rtl/seq_serializer_pkg.sv
// Shared types, widths and the length clamp rule for the serial pattern transmitter.
package seq_serializer_pkg;

    localparam int SER_WIDTH = 8;
    localparam int LEN_W     = $clog2(SER_WIDTH + 1);
    localparam int IDX_W     = $clog2(SER_WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_e;

    // A length of zero or beyond the pattern register means "send the whole register".
    function automatic int eff_len(input int len, input int width);
        int res;
        if ((len == 0) || (len > width)) begin
            res = width;
        end else begin
            res = len;
        end
        return res;
    endfunction

endpackage

// File: rtl/seq_serializer_if.sv
// Request/serial-stream bundle between a pattern source and the serializer.
interface seq_serializer_if
    import seq_serializer_pkg::*;
#(
    parameter int WIDTH = SER_WIDTH,
    parameter int REP_W = 4
);
    localparam int LW = $clog2(WIDTH + 1);

    logic             start;
    logic             ready;
    logic [WIDTH-1:0] pattern;
    logic [LW-1:0]    len;
    logic [REP_W-1:0] reps;
    logic             abort;
    logic             s_out;
    logic             s_valid;
    logic             busy;
    logic             done;

    modport master (
        output start, pattern, len, reps, abort,
        input  ready, s_out, s_valid, busy, done
    );

    modport slave (
        input  start, pattern, len, reps, abort,
        output ready, s_out, s_valid, busy, done
    );
endinterface

// File: rtl/piso_shift_reg.sv
// Parallel-load, MSB-first shift register; FILL enters at the LSB and is the reset value.
module piso_shift_reg #(
    parameter int   WIDTH = 8,
    parameter logic FILL  = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] din,
    output logic             msb
);
    logic [WIDTH-1:0] sr_q;
    logic [WIDTH-1:0] sr_d;

    // Next register contents: load has priority over shift.
    always_comb begin
        sr_d = sr_q;
        if (load) begin
            sr_d = din;
        end else if (shift) begin
            sr_d = {sr_q[WIDTH-2:0], FILL};
        end else begin
            sr_d = sr_q;
        end
    end

    // Shift register state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr_q <= {WIDTH{FILL}};
        end else begin
            sr_q <= sr_d;
        end
    end

    assign msb = sr_q[WIDTH-1];
endmodule

// File: rtl/seq_serializer.sv
// Serial pattern transmitter: shifts a latched pattern out MSB-first with
// programmable length, repeat count and fixed idle gaps between repeats.
module seq_serializer
    import seq_serializer_pkg::*;
#(
    parameter int   WIDTH      = SER_WIDTH,
    parameter int   REP_W      = 4,
    parameter int   GAP_CYCLES = 0,
    parameter logic IDLE_LVL   = 1'b0
) (
    input logic             clk,
    input logic             rst,
    seq_serializer_if.slave bus
);
    localparam int LW = $clog2(WIDTH + 1);
    localparam int IW = $clog2(WIDTH);
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] pat_q, pat_d;
    logic [LW-1:0]    len_q, len_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [REP_W-1:0] rep_q, rep_d;
    logic [GW-1:0]    gap_q, gap_d;
    logic             s_valid_q, s_valid_d;
    logic             done_q, done_d;

    logic             load_s;
    logic             shift_s;
    logic [WIDTH-1:0] load_val_s;
    logic [LW-1:0]    len_eff_s;
    logic [WIDTH-1:0] align_s;

    // The pattern is stored left-aligned so its first bit always sits at the shift-out end.
    assign len_eff_s = LW'(eff_len(int'(bus.len), WIDTH));
    assign align_s   = bus.pattern << (LW'(WIDTH) - len_eff_s);

    // FSM, bit index, repetition and gap counters.
    always_comb begin
        state_d    = state_q;
        pat_d      = pat_q;
        len_d      = len_q;
        idx_d      = idx_q;
        rep_d      = rep_q;
        gap_d      = gap_q;
        s_valid_d  = 1'b0;
        done_d     = 1'b0;
        load_s     = 1'b0;
        shift_s    = 1'b0;
        load_val_s = {WIDTH{IDLE_LVL}};
        case (state_q)
            IDLE: begin
                if (bus.start && !bus.abort) begin
                    state_d    = SEND;
                    pat_d      = align_s;
                    len_d      = len_eff_s;
                    idx_d      = IW'(len_eff_s - LW'(1));
                    rep_d      = (bus.reps == REP_W'(0)) ? REP_W'(0) : bus.reps - REP_W'(1);
                    load_s     = 1'b1;
                    load_val_s = align_s;
                    s_valid_d  = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            SEND: begin
                if (bus.abort) begin
                    state_d = IDLE;
                    load_s  = 1'b1;
                end else if (idx_q != IW'(0)) begin
                    idx_d     = idx_q - IW'(1);
                    shift_s   = 1'b1;
                    s_valid_d = 1'b1;
                end else if (rep_q != REP_W'(0)) begin
                    rep_d = rep_q - REP_W'(1);
                    if (GAP_CYCLES > 0) begin
                        state_d = GAP;
                        gap_d   = GW'(GAP_CYCLES - 1);
                        load_s  = 1'b1;
                    end else begin
                        idx_d      = IW'(len_q - LW'(1));
                        load_s     = 1'b1;
                        load_val_s = pat_q;
                        s_valid_d  = 1'b1;
                    end
                end else begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    load_s  = 1'b1;
                end
            end
            GAP: begin
                if (bus.abort) begin
                    state_d = IDLE;
                end else if (gap_q == GW'(0)) begin
                    state_d    = SEND;
                    idx_d      = IW'(len_q - LW'(1));
                    load_s     = 1'b1;
                    load_val_s = pat_q;
                    s_valid_d  = 1'b1;
                end else begin
                    gap_d = gap_q - GW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                load_s  = 1'b1;
            end
        endcase
    end

    // Control state and registered handshake outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            pat_q     <= {WIDTH{1'b0}};
            len_q     <= LW'(0);
            idx_q     <= IW'(0);
            rep_q     <= REP_W'(0);
            gap_q     <= GW'(0);
            s_valid_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pat_q     <= pat_d;
            len_q     <= len_d;
            idx_q     <= idx_d;
            rep_q     <= rep_d;
            gap_q     <= gap_d;
            s_valid_q <= s_valid_d;
            done_q    <= done_d;
        end
    end

    // Idle fill is loaded whenever the line leaves a frame, so s_out is a plain flop output.
    piso_shift_reg #(
        .WIDTH (WIDTH),
        .FILL  (IDLE_LVL)
    ) u_piso (
        .clk   (clk),
        .rst   (rst),
        .load  (load_s),
        .shift (shift_s),
        .din   (load_val_s),
        .msb   (bus.s_out)
    );

    assign bus.s_valid = s_valid_q;
    assign bus.done    = done_q;
    assign bus.ready   = (state_q == IDLE);
    assign bus.busy    = (state_q != IDLE);
endmodule

// File: tb/tb_seq_serializer.sv
// Scoreboard bench: a frame-level reference model predicts every output cycle.
module tb_seq_serializer;
    import seq_serializer_pkg::*;

    localparam int   W   = 8;
    localparam int   RW  = 4;
    localparam int   GP  = 2;
    localparam logic IL  = 1'b0;
    localparam int   LWB = LEN_W;

    typedef struct packed {
        logic v;
        logic o;
        logic d;
        logic r;
    } exp_t;

    logic clk;
    logic rst = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    exp_t frame[$];
    exp_t sb[$];

    seq_serializer_if #(.WIDTH(W), .REP_W(RW)) bus ();

    seq_serializer #(
        .WIDTH      (W),
        .REP_W      (RW),
        .GAP_CYCLES (GP),
        .IDLE_LVL   (IL)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic exp_t idle_e();
        exp_t e;
        e.v = 1'b0;
        e.o = IL;
        e.d = 1'b0;
        e.r = 1'b1;
        return e;
    endfunction

    // Whole-frame expansion from the stated rules: reps groups of len bits, gaps between, then done.
    task automatic build(input logic [W-1:0] p, input int l, input int r);
        exp_t e;
        int   le;
        int   re;
        le = (l == 0 || l > W) ? W : l;
        re = (r == 0) ? 1 : r;
        for (int k = 0; k < re; k++) begin
            for (int i = le - 1; i >= 0; i--) begin
                e.v = 1'b1; e.o = p[i]; e.d = 1'b0; e.r = 1'b0;
                frame.push_back(e);
            end
            if (k < re - 1) begin
                for (int g = 0; g < GP; g++) begin
                    e.v = 1'b0; e.o = IL; e.d = 1'b0; e.r = 1'b0;
                    frame.push_back(e);
                end
            end
        end
        e.v = 1'b0; e.o = IL; e.d = 1'b1; e.r = 1'b1;
        frame.push_back(e);
    endtask

    // Reference model: predicts the output of the cycle following each edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                frame.delete();
                sb.delete();
                sb.push_back(idle_e());
            end else begin
                if (frame.size() > 0) begin
                    if (bus.abort) begin
                        frame.delete();
                        e = idle_e();
                    end else begin
                        e = frame.pop_front();
                    end
                end else if (bus.start && !bus.abort) begin
                    build(bus.pattern, int'(bus.len), int'(bus.reps));
                    e = frame.pop_front();
                end else begin
                    e = idle_e();
                end
                e.r = (frame.size() == 0);
                sb.push_back(e);
            end
        end
    end

    // Monitor: compares the DUT's outputs against the scoreboard mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                vectors++;
                if (bus.s_valid !== e.v || bus.s_out !== e.o || bus.done !== e.d ||
                    bus.ready !== e.r || bus.busy !== !e.r) begin
                    miscompares++;
                    $display("FAIL cycle @%0t: got v=%b o=%b done=%b rdy=%b busy=%b, want v=%b o=%b done=%b rdy=%b busy=%b",
                             $time, bus.s_valid, bus.s_out, bus.done, bus.ready, bus.busy,
                             e.v, e.o, e.d, e.r, !e.r);
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic [W-1:0] p, input int l, input int r);
        @(negedge clk);
        bus.pattern = p;
        bus.len     = LWB'(l);
        bus.reps    = RW'(r);
        bus.start   = 1'b1;
        @(negedge clk);
        bus.start   = 1'b0;
    endtask

    initial begin
        bus.start   = 1'b0;
        bus.abort   = 1'b0;
        bus.pattern = {W{1'b0}};
        bus.len     = LWB'(0);
        bus.reps    = RW'(0);
        #1 rst = 1'b1;
        idle(2);
        rst = 1'b0;
        idle(2);

        send(8'h0D, 4, 1);            // basic: 1,1,0,1 then done
        idle(8);
        send(8'h05, 3, 3);            // 101 x3 with two-cycle gaps
        idle(18);
        send(8'hA5, 0, 0);            // clamp to 8 bits, single repetition
        idle(12);

        send(8'hC3, 8, 1);            // start during SEND must be ignored
        idle(2);
        bus.pattern = 8'hFF;
        bus.len     = LWB'(2);
        bus.start   = 1'b1;
        @(negedge clk);
        bus.start   = 1'b0;
        idle(10);

        send(8'hB6, 8, 1);            // abort during the third bit
        idle(1);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        idle(6);

        @(negedge clk);               // abort with start in IDLE: nothing sent
        bus.start = 1'b1;
        bus.abort = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.abort = 1'b0;
        idle(4);

        @(negedge clk);               // start held: back-to-back two-bit frames
        bus.pattern = 8'h03;
        bus.len     = LWB'(2);
        bus.reps    = RW'(1);
        bus.start   = 1'b1;
        idle(12);
        bus.start   = 1'b0;
        idle(5);

        send(8'hFF, 8, 2);            // asynchronous reset in the middle of a frame
        idle(3);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        vectors++;
        if (bus.s_valid !== 1'b0 || bus.s_out !== IL || bus.ready !== 1'b1 || bus.done !== 1'b0) begin
            miscompares++;
            $display("FAIL async_reset: got v=%b o=%b rdy=%b done=%b, want v=0 o=%b rdy=1 done=0",
                     bus.s_valid, bus.s_out, bus.ready, bus.done, IL);
        end
        #1 rst = 1'b0;
        idle(3);

        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            bus.start   = ($urandom_range(0, 3) == 0);
            bus.abort   = ($urandom_range(0, 40) == 0);
            bus.pattern = W'($urandom);
            bus.len     = LWB'($urandom_range(0, 15));
            bus.reps    = ($urandom_range(0, 9) == 0) ? RW'(15) : RW'($urandom_range(0, 3));
        end
        @(negedge clk);
        bus.start = 1'b0;
        bus.abort = 1'b0;
        idle(200);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/seq_serializer.md
Name: seq_serializer

Overview:
Serial pattern transmitter; the generating counterpart of the team's serial sequence detector. Accepts a parallel bit pattern with a start handshake and shifts it out MSB-first, one bit per clock, on a single-bit line. That line is wired directly to a detector's serial input `e`. Supports a programmable pattern length, a repeat count and idle gap cycles between repeats, so benches and top-levels can drive detectors with continuous or framed streams.

Parameters:
- WIDTH, 8, maximum pattern length in bits (>=2).
- REP_W, 4, width of the repeat-count input.
- GAP_CYCLES, 0, idle cycles inserted between consecutive repetitions (0 = back-to-back).
- IDLE_LVL, 1'b0, level driven on s_out whenever s_valid=0.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request; accepted only when ready=1.
- ready  out  1  high in IDLE.
- pattern  in  WIDTH  bits to send; the first bit sent is pattern[len-1].
- len  in  $clog2(WIDTH+1)  number of bits; 0 or >WIDTH is treated as WIDTH.
- reps  in  REP_W  total transmissions; 0 is treated as 1.
- abort  in  1  synchronous cancel.
- s_out  out  1  serial data.
- s_valid  out  1  s_out carries a pattern bit this cycle.
- busy  out  1  high in SEND or GAP.
- done  out  1  one-cycle pulse on normal completion.

Behaviour:
- Reset, asserted asynchronously at any time including mid-frame: state=IDLE, ready=1, s_out=IDLE_LVL, s_valid=0, busy=0, done=0. All latched pattern, length and counters are cleared.
- States: IDLE, SEND, GAP.
- IDLE:
  - On a posedge with start=1 and abort=0, latch pattern, effective len and effective reps, then go to SEND.
  - start while busy is ignored and never queued.
- SEND:
  - The first bit appears the cycle after acceptance. Latency is 1 clock from the start edge to the first s_valid.
  - Bits go out pattern[len-1] down to pattern[0], one per cycle, with s_valid=1.
  - Bit index counts down from len-1.
  - At bit 0:
    - If repetitions remain and GAP_CYCLES>0, go to GAP.
    - If repetitions remain and GAP_CYCLES=0, go back to SEND with the index reloaded. There is no bubble: the first bit of the next repetition follows immediately.
    - If no repetitions remain, go to IDLE.
- GAP: hold exactly GAP_CYCLES cycles with s_valid=0 and s_out=IDLE_LVL, then go to SEND.
- done:
  - High for exactly one cycle: the first IDLE cycle after the last bit of the last repetition.
  - ready is also 1 in that cycle, so a start seen at that edge is accepted. Back-to-back frames are therefore separated by exactly one non-valid cycle.
- abort:
  - Sampled at posedge. In SEND or GAP it forces IDLE on the next cycle; no done is generated and the rest of the frame is dropped.
  - abort in IDLE has no effect. abort together with start in IDLE: abort wins and start is not accepted.
- Timing: total valid cycles = reps_eff*len_eff. Frame duration = reps_eff*len_eff + (reps_eff-1)*GAP_CYCLES.
- Width rules:
  - The repetition counter is REP_W bits, so the maximum reps is 2^REP_W-1.
  - The bit index is $clog2(WIDTH) bits and must not wrap below 0.
- Outputs are registered (no combinational path from inputs to s_out, s_valid or done). ready = (state==IDLE).

Decomposition:
- Package seq_serializer_pkg holds:
  - state enum {IDLE, SEND, GAP};
  - localparams LEN_W=$clog2(WIDTH+1) and IDX_W=$clog2(WIDTH);
  - the function eff_len(len) for the clamp rule.
- One sub-module, piso_shift_reg: a parallel-load, MSB-first shift register with load/shift enables and async active-high reset.
- The top level holds the FSM, the repetition counter and the gap counter.

Test Plan:
- Reset mid-frame: rst pulsed between clock edges while sending -> s_out=IDLE_LVL, s_valid=0 and ready=1 immediately, before the next edge; no done.
- Basic frame (WIDTH=8): pattern=8'b0000_1101, len=4, reps=1, start for 1 cycle -> s_out=1,1,0,1 with s_valid=1 on cycles 1..4 after the start edge; done on cycle 5. When fed to the detector, the detector output s asserts once.
- Repeats with gap (GAP_CYCLES=2): pattern=3'b101, len=3, reps=3 -> valid stream 101,--,101,--,101 with exactly 2 non-valid cycles between groups; 9 valid bits total; a single done.
- Clamp rules: len=0 and reps=0 with pattern=8'hA5 -> 8 bits 1,0,1,0,0,1,0,1 sent once; done.
- Busy and abort: start pulsed again during SEND -> ignored, and the frame is unchanged. abort at the 3rd bit -> s_valid low the next cycle, IDLE, no done. abort+start in IDLE -> no frame.
- Back-to-back: start held high continuously with len=2, pattern=2'b11 -> frames separated by exactly one non-valid cycle, with done pulsing in each gap.
